// File: rtl/pkg_ili9341.sv
// Shared definitions for the ILI9341 panel controller: pin levels and the
// reset sequencer state encoding.
package pkg_ili9341;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Encodings are visible on o_phase, so they are fixed explicitly.
  typedef enum logic [2:0] {
    RST_IDLE    = 3'd0,
    RST_PRE_H   = 3'd1,
    RST_PULSE_L = 3'd2,
    RST_POST_H  = 3'd3,
    RST_DONE    = 3'd4
  } rst_seq_state_t;

  // True for the three phases whose length is set by a T_* parameter.
  function automatic logic is_timed_phase(input rst_seq_state_t s);
    return (s == RST_PRE_H) || (s == RST_PULSE_L) || (s == RST_POST_H);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating down-counter used to time the reset sequencer phases.
// Clear beats load, load beats decrement; the count never wraps below zero.
module seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, reload, or decrement holding at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/ili9341_reset_seq.sv
// ILI9341 hardware-reset sequencer: drives RESX high, then low, then waits
// high again before reporting completion. Phases are timed by an internal
// down-counter, or advanced by i_step when EXT_PACE is set.
module ili9341_reset_seq
  import pkg_ili9341::*;
#(
  parameter int          CNT_W    = 24,
  parameter int unsigned T_PRE    = 10,
  parameter int unsigned T_LOW    = 1000,
  parameter int unsigned T_POST   = 12_000_000,
  parameter int          EXT_PACE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_step,
  input  logic       i_abort,
  output logic       o_reset_ena,
  output logic       o_reset_val,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_phase
);

  // A phase of length T is loaded as T-1 so that it ends on the cycle the
  // counter reads zero; T = 2**CNT_W therefore still fits the counter.
  localparam longint unsigned T_MAX = 64'd1 << CNT_W;

  if ((T_PRE < 1) || (T_LOW < 1) || (T_POST < 1) ||
      (64'(T_PRE) > T_MAX) || (64'(T_LOW) > T_MAX) || (64'(T_POST) > T_MAX))
  begin : g_param_check
    $error("ili9341_reset_seq: every T_* must lie in [1, 2**CNT_W]");
  end

  localparam logic [CNT_W-1:0] LD_PRE  = CNT_W'(T_PRE - 1);
  localparam logic [CNT_W-1:0] LD_LOW  = CNT_W'(T_LOW - 1);
  localparam logic [CNT_W-1:0] LD_POST = CNT_W'(T_POST - 1);
  localparam logic             EXT     = (EXT_PACE != 0);

  rst_seq_state_t   state_q;
  rst_seq_state_t   state_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_clr;
  logic             tmr_zero;
  logic             phase_end;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_dec      (tmr_dec),
    .i_clr      (tmr_clr),
    .o_zero     (tmr_zero)
  );

  // Next-state and timer control; abort always wins over phase advance.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    tmr_clr      = 1'b0;
    phase_end    = EXT ? i_step : tmr_zero;

    case (state_q)
      RST_IDLE: begin
        if (!i_abort && i_start) begin
          state_d      = RST_PRE_H;
          tmr_load     = 1'b1;
          tmr_load_val = LD_PRE;
        end
      end
      RST_PRE_H: begin
        if (i_abort) begin
          state_d = RST_IDLE;
          tmr_clr = 1'b1;
        end else if (phase_end) begin
          state_d      = RST_PULSE_L;
          tmr_load     = 1'b1;
          tmr_load_val = LD_LOW;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RST_PULSE_L: begin
        if (i_abort) begin
          state_d = RST_IDLE;
          tmr_clr = 1'b1;
        end else if (phase_end) begin
          state_d      = RST_POST_H;
          tmr_load     = 1'b1;
          tmr_load_val = LD_POST;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RST_POST_H: begin
        if (i_abort) begin
          state_d = RST_IDLE;
          tmr_clr = 1'b1;
        end else if (phase_end) begin
          state_d = RST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RST_DONE: begin
        state_d = RST_IDLE;
        tmr_clr = i_abort;
      end
      default: begin
        state_d = RST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase

    // In externally paced mode the counter is parked and never consulted.
    if (EXT) begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; RESX idles high whenever the driver is disabled.
  always_comb begin
    o_reset_ena = LOW;
    o_reset_val = HIGH;
    o_busy      = LOW;
    o_done      = LOW;
    o_phase     = RST_IDLE;

    case (state_q)
      RST_PRE_H: begin
        o_reset_ena = HIGH;
        o_busy      = HIGH;
        o_phase     = RST_PRE_H;
      end
      RST_PULSE_L: begin
        o_reset_ena = HIGH;
        o_reset_val = LOW;
        o_busy      = HIGH;
        o_phase     = RST_PULSE_L;
      end
      RST_POST_H: begin
        o_reset_ena = HIGH;
        o_busy      = HIGH;
        o_phase     = RST_POST_H;
      end
      RST_DONE: begin
        o_busy  = HIGH;
        o_done  = HIGH;
        o_phase = RST_DONE;
      end
      default: begin
        o_phase = RST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ili9341_reset_seq.sv
// Bench for ili9341_reset_seq: three instances (counter timed, externally
// paced, and a counter sized exactly to its longest phase) driven by directed
// steps; each step queues the output vector expected after the next edge.
module tb_ili9341_reset_seq;

  // Output vector layout: {ena, val, busy, done, phase[2:0]}
  localparam logic [6:0] E_IDLE = 7'b0100000;
  localparam logic [6:0] E_PRE  = 7'b1110001;
  localparam logic [6:0] E_LOW  = 7'b1010010;
  localparam logic [6:0] E_POST = 7'b1110011;
  localparam logic [6:0] E_DONE = 7'b0111100;

  typedef struct {
    int         cyc;
    int         inst;
    logic [6:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] abort;
  logic       step;
  logic       ena   [3];
  logic       val   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [2:0] phase [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter timed, T = 2/3/4
  ili9341_reset_seq #(.CNT_W(24), .T_PRE(2), .T_LOW(3), .T_POST(4), .EXT_PACE(0)) u_timed (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_step(step), .i_abort(abort[0]),
    .o_reset_ena(ena[0]), .o_reset_val(val[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_phase(phase[0]));

  // Externally paced, default timing parameters
  ili9341_reset_seq #(.EXT_PACE(1)) u_ext (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_step(step), .i_abort(abort[1]),
    .o_reset_ena(ena[1]), .o_reset_val(val[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_phase(phase[1]));

  // Boundary: T_LOW = T_POST = 2**CNT_W, T_PRE at its minimum
  ili9341_reset_seq #(.CNT_W(2), .T_PRE(1), .T_LOW(4), .T_POST(4), .EXT_PACE(0)) u_bound (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_step(step), .i_abort(abort[2]),
    .o_reset_ena(ena[2]), .o_reset_val(val[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_phase(phase[2]));

  function automatic logic [6:0] obs(input int i);
    return {ena[i], val[i], busy[i], done[i], phase[i]};
  endfunction

  // Scoreboard: compare every queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      tests++;
      assert (obs(e.inst) === e.exp)
      else begin
        fails++;
        $error("FAIL %s inst%0d cyc%0d: observed %b expected %b",
               e.tag, e.inst, e.cyc, obs(e.inst), e.exp);
      end
    end
  end

  task automatic drive(input int inst, input logic st, input logic ab, input logic sp,
                       input logic [6:0] exp, input string tag);
    start       = '0;
    abort       = '0;
    start[inst] = st;
    abort[inst] = ab;
    step        = sp;
    sb_q.push_back('{cyc: cyc + 1, inst: inst, exp: exp, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst   = 1'b0;
    start = '1;
    abort = '0;
    step  = 1'b0;
    for (int i = 0; i < 3; i++)
      sb_q.push_back('{cyc: cyc + 1, inst: i, exp: E_IDLE, tag: "reset"});
    @(posedge clk);
    #1;
  endtask

  // One complete sequence started from IDLE, with optional input noise held
  // throughout; phase lengths come straight from the instance parameters.
  task automatic run_seq(input int inst, input int tp, input int tl, input int tpo,
                         input logic st_noise, input logic sp_noise, input string tag);
    drive(inst, 1'b1, 1'b0, sp_noise, E_PRE, tag);
    for (int k = 1; k < tp; k++) drive(inst, st_noise, 1'b0, sp_noise, E_PRE, tag);
    for (int k = 0; k < tl; k++) drive(inst, st_noise, 1'b0, sp_noise, E_LOW, tag);
    for (int k = 0; k < tpo; k++) drive(inst, st_noise, 1'b0, sp_noise, E_POST, tag);
    drive(inst, st_noise, 1'b0, sp_noise, E_DONE, tag);
    drive(inst, 1'b0, 1'b0, 1'b0, E_IDLE, tag);
  endtask

  initial begin
    logic [6:0] b2b [13];
    logic [6:0] ex;
    int         n;

    rst   = 1'b0;
    start = '0;
    abort = '0;
    step  = 1'b0;
    #1;

    for (int k = 0; k < 3; k++) reset_cycle();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, E_IDLE, "idle_after_rst");

    // Nominal run; i_step noise must be ignored in counter mode
    run_seq(0, 2, 3, 4, 1'b0, 1'b1, "nominal");

    // Abort on the second PULSE_L cycle; no done may follow
    drive(0, 1'b1, 1'b0, 1'b0, E_PRE, "abort_low");
    drive(0, 1'b0, 1'b0, 1'b0, E_PRE, "abort_low");
    drive(0, 1'b0, 1'b0, 1'b0, E_LOW, "abort_low");
    drive(0, 1'b0, 1'b0, 1'b0, E_LOW, "abort_low");
    drive(0, 1'b0, 1'b1, 1'b0, E_IDLE, "abort_low");
    for (int k = 0; k < 10; k++) drive(0, 1'b0, 1'b0, 1'b0, E_IDLE, "abort_quiet");

    // Abort beats start in IDLE
    drive(0, 1'b1, 1'b1, 1'b0, E_IDLE, "abort_vs_start");
    drive(0, 1'b0, 1'b0, 1'b0, E_IDLE, "abort_vs_start");

    // Start held during the sequence is ignored; exactly one done
    run_seq(0, 2, 3, 4, 1'b1, 1'b0, "start_in_seq");

    // Back-to-back with start held high, then abort in PRE_H
    b2b = '{E_PRE, E_PRE, E_LOW, E_LOW, E_LOW, E_POST, E_POST, E_POST, E_POST,
            E_DONE, E_IDLE, E_PRE, E_PRE};
    for (int k = 0; k < 13; k++) drive(0, 1'b1, 1'b0, 1'b0, b2b[k], "back_to_back");
    drive(0, 1'b0, 1'b1, 1'b0, E_IDLE, "abort_pre");

    // Reset mid-sequence overrides start
    drive(0, 1'b1, 1'b0, 1'b0, E_PRE, "rst_mid");
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, E_IDLE, "rst_mid");
    drive(0, 1'b1, 1'b0, 1'b0, E_IDLE, "rst_mid");
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, E_IDLE, "rst_mid");
    run_seq(0, 2, 3, 4, 1'b0, 1'b0, "after_rst");

    // Counter sized exactly to the longest phase: no wrap
    run_seq(2, 1, 4, 4, 1'b0, 1'b0, "boundary");

    // Externally paced: step in IDLE ignored, steps at cycles 5, 6 and 20
    drive(1, 1'b0, 1'b0, 1'b1, E_IDLE, "ext_step_idle");
    drive(1, 1'b0, 1'b0, 1'b0, E_IDLE, "ext_step_idle");
    drive(1, 1'b1, 1'b0, 1'b0, E_PRE, "ext");
    for (int k = 1; k <= 20; k++) begin
      n  = k + 1;
      ex = (n <= 5) ? E_PRE : (n == 6) ? E_LOW : (n <= 20) ? E_POST : E_DONE;
      drive(1, 1'b0, 1'b0, (k == 5 || k == 6 || k == 20), ex, "ext");
    end
    drive(1, 1'b0, 1'b0, 1'b1, E_IDLE, "ext_step_done");
    drive(1, 1'b0, 1'b0, 1'b1, E_IDLE, "ext_step_idle2");

    drive(0, 1'b0, 1'b0, 1'b0, E_IDLE, "tail");
    @(negedge clk);
    #1;

    tests++;
    assert (sb_q.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ili9341_reset_seq.md
# ili9341_reset_seq

Self-timed hardware-reset sequencer for the ILI9341 panel. It drives the panel RESX line through high-hold, low-pulse and post-reset-wait phases whose lengths are set by parameters and counted internally. An external-pacing mode keeps compatibility with step-driven top-level sequencers. It sits between the top-level init FSM and the RESX pin driver, ahead of the command/data init ROM sequencer.

## Interface
- `CNT_W`, 24: width of the phase down-counter.
- `T_PRE`, 10: clock cycles RESX is held high before the pulse. Must be ≥1.
- `T_LOW`, 1000: clock cycles RESX is held low. Must be ≥1.
- `T_POST`, 12_000_000: clock cycles of high wait after release (120 ms at 100 MHz). Must be ≥1.
- `EXT_PACE`, 0: 0 means phases are timed by the internal counter; 1 means phases advance on `i_step` and the counter is unused.
- Parameter rule: every `T_*` must satisfy `T_* ≤ 2^CNT_W`. This is checked by an elaboration-time assertion.

Ports:
- `clk` input, 1: the only clock.
- `rst` input, 1: synchronous, active-low reset.
- `i_start` input, 1: request a reset sequence. Sampled only in IDLE.
- `i_step` input, 1: phase advance, used only when `EXT_PACE`=1.
- `i_abort` input, 1: cancel the sequence and return to IDLE.
- `o_reset_ena` output, 1: RESX driver enable. High in PRE_H, PULSE_L and POST_H.
- `o_reset_val` output, 1: RESX level. Low only in PULSE_L; high otherwise.
- `o_busy` output, 1: high in every state except IDLE.
- `o_done` output, 1: one-cycle pulse in DONE.
- `o_phase` output, 3: encoded current state, for debug and ILA.

## Operation
- States and encodings: IDLE=0, PRE_H=1, PULSE_L=2, POST_H=3, DONE=4.
- Unused encodings decode like IDLE and go to IDLE on the next edge.
- Transitions:
  - IDLE → PRE_H on `i_start`.
  - PRE_H → PULSE_L → POST_H → DONE, each on its phase-end event.
  - DONE → IDLE unconditionally.
- Phase-end event:
  - `EXT_PACE`=0: the counter equals 0.
  - `EXT_PACE`=1: `i_step`=1.
- Counter behaviour:
  - Loaded with `T_next-1` on the edge that enters PRE_H, PULSE_L or POST_H.
  - Decrements by 1 per cycle while in a timed phase.
  - Never wraps: it holds at 0.
- Abort: `i_abort`=1 in PRE_H, PULSE_L, POST_H or DONE → IDLE next edge.
  - No `o_done` pulse.
  - Counter cleared.
- Priority on simultaneous events:
  - `i_abort` beats a phase-end event.
  - `i_abort` beats `i_start` in IDLE: the block stays in IDLE.
- Ignored inputs:
  - `i_start` outside IDLE.
  - `i_step` in IDLE or DONE, and whenever `EXT_PACE`=0.
- Outputs are Moore, decoded from the state only. `o_reset_val`=1 whenever `o_reset_ena`=0, so the line idles high.

## Timing
- Reset: an edge with `rst`=0 sets state to IDLE and counter to 0. From that edge:
  - `o_reset_ena`=0, `o_reset_val`=1.
  - `o_busy`=0, `o_done`=0, `o_phase`=0.
- `rst` low mid-sequence behaves like abort and also overrides `i_start`.
- Start latency: `i_start` sampled at edge E0 → PRE_H outputs visible in the cycle after E0.
- `EXT_PACE`=0 phase lengths:
  - PRE_H lasts exactly `T_PRE` cycles, PULSE_L exactly `T_LOW`, POST_H exactly `T_POST`.
  - `o_done` is high in cycle E0+`T_PRE`+`T_LOW`+`T_POST`+1 for exactly 1 cycle.
  - IDLE follows. `i_start` is accepted again on that first IDLE cycle's edge.
- `EXT_PACE`=1: each phase lasts from entry until the first cycle with `i_step`=1, minimum 1 cycle. The step is consumed on that edge.
- Back-to-back: `i_start` held high continuously gives one DONE cycle plus one IDLE cycle between sequences.

## Structure
- Package `pkg_ili9341`:
  - Add `rst_seq_state_t`, a 3-bit enum with the encodings above.
  - Reuse the existing LOW/HIGH constants.
- Sub-module `seq_timer`, parametrised by `CNT_W`:
  - Synchronous down-counter with `i_load`, `i_load_val`, `i_dec` and `i_clr`.
  - Outputs `o_zero`; saturates at 0.
  - The sequencer FSM instantiates it once.

## Test plan
Timed tests use `T_PRE`=2, `T_LOW`=3, `T_POST`=4 unless stated.
- Reset check: `rst`=0 for 3 cycles with `i_start`=1 → outputs ena=0, val=1, busy=0, done=0, phase=0 throughout.
- Nominal run: 1-cycle `i_start` → ena=1 for 9 cycles with val pattern 1,1,0,0,0,1,1,1,1. Then `o_done`=1 for 1 cycle, then busy=0.
- Abort in PULSE_L (2nd low cycle) → next cycle ena=0, val=1, phase=0. `o_done` never asserts.
- Simultaneous `i_abort` and `i_start` in IDLE → remains IDLE, busy=0. Separately, `i_start` pulses during POST_H → ignored; exactly one `o_done`.
- `EXT_PACE`=1, steps at cycles 5, 6 and 20 after start:
  - PRE_H lasts 5 cycles, PULSE_L 1, POST_H 14; then done.
  - An `i_step` in IDLE has no effect.
- Default parameters with `T_POST`=12_000_000 and `CNT_W`=24 → POST_H lasts exactly 12,000,000 cycles, with no counter wrap.
